// File: rtl/rst_seq_sys.sv
// Reset sequencer: synchronizes the board reset, releases peripherals then core, and services soft/watchdog core resets.
// Optional watchdog built with `define RST_SEQ_WDT_EN (default build: no watchdog, reset_cause never 10).
module rst_seq_sys #(
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 4,
  parameter int SOFT_CYCLES = 8,
  parameter int WDT_CYCLES  = 1048576
) (
  input  logic       clk_sys,
  input  logic       rst_sys,
  input  logic       sreq,
  input  logic       wdt_kick,
  output logic       rst_periph_n,
  output logic       rst_core_n,
  output logic       seq_done,
  output logic       sreq_ack,
  output logic [1:0] reset_cause
);

  localparam int MAX_HS = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam int MAX_C  = (MAX_HS > SOFT_CYCLES) ? MAX_HS : SOFT_CYCLES;
  localparam int CW     = $clog2(MAX_C) + 1;

  typedef enum logic [2:0] {S_SYNC, S_HOLD, S_PERIPH, S_RUN, S_SOFT} state_t;

  state_t      state_q, state_d;
  logic [1:0]  sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        armed_q, armed_d;
  logic        ack_pend_q, ack_pend_d;
  logic        periph_q, periph_d;
  logic        core_q, core_d;
  logic        done_q, done_d;
  logic        ack_q, ack_d;
  logic [1:0]  cause_q, cause_d;
  logic        accept;
  logic        wdt_to;

`ifdef RST_SEQ_WDT_EN
  localparam int WW = $clog2(WDT_CYCLES) + 1;
  logic [WW-1:0] wdt_q, wdt_d;

  always_comb begin
    wdt_to = 1'b0;
    wdt_d  = '0;
    if (state_q == S_RUN && !wdt_kick) begin
      if (wdt_q == WW'(WDT_CYCLES - 1)) wdt_to = 1'b1;
      else                              wdt_d  = wdt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_sys or posedge rst_sys) begin
    if (rst_sys) wdt_q <= '0;
    else         wdt_q <= wdt_d;
  end
`else
  localparam int wdt_cycles_unused = WDT_CYCLES;
  logic wdt_kick_unused;
  assign wdt_kick_unused = wdt_kick;
  assign wdt_to = 1'b0;
`endif

  assign accept = (state_q == S_RUN) && sreq && armed_q;

  always_comb begin
    state_d    = state_q;
    sync_d     = {sync_q[0], 1'b0};
    cnt_d      = cnt_q;
    armed_d    = sreq ? armed_q : 1'b1;
    ack_pend_d = ack_pend_q;
    periph_d   = periph_q;
    core_d     = core_q;
    done_d     = done_q;
    ack_d      = 1'b0;
    cause_d    = cause_q;
    case (state_q)
      // The release-detection edge is the first hold cycle, absorbing the synchronizer lag.
      S_SYNC: begin
        if (!sync_q[1]) begin
          if (HOLD_CYCLES <= 1) begin
            periph_d = 1'b1;
            cnt_d    = CW'(STAGE_GAP - 1);
            state_d  = S_PERIPH;
          end else begin
            cnt_d    = CW'(HOLD_CYCLES - 1);
            state_d  = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= CW'(1)) begin
          periph_d = 1'b1;
          cnt_d    = CW'(STAGE_GAP - 1);
          state_d  = S_PERIPH;
        end
      end
      S_PERIPH: begin
        if (cnt_q == '0) begin
          core_d  = 1'b1;
          done_d  = 1'b1;
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RUN: begin
        if (wdt_to || accept) begin
          core_d  = 1'b0;
          done_d  = 1'b0;
          cnt_d   = CW'(SOFT_CYCLES - 1);
          cause_d = wdt_to ? 2'b10 : 2'b01;
          state_d = S_SOFT;
        end
        // A request coinciding with a watchdog timeout is still consumed and acknowledged.
        if (accept) begin
          armed_d    = 1'b0;
          ack_pend_d = 1'b1;
        end
      end
      S_SOFT: begin
        if (cnt_q == '0) begin
          core_d     = 1'b1;
          done_d     = 1'b1;
          ack_d      = ack_pend_q;
          ack_pend_d = 1'b0;
          state_d    = S_RUN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_SYNC;
    endcase
  end

  always_ff @(posedge clk_sys or posedge rst_sys) begin
    if (rst_sys) begin
      state_q    <= S_SYNC;
      sync_q     <= 2'b11;
      cnt_q      <= '0;
      armed_q    <= 1'b1;
      ack_pend_q <= 1'b0;
      periph_q   <= 1'b0;
      core_q     <= 1'b0;
      done_q     <= 1'b0;
      ack_q      <= 1'b0;
      cause_q    <= 2'b00;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      cnt_q      <= cnt_d;
      armed_q    <= armed_d;
      ack_pend_q <= ack_pend_d;
      periph_q   <= periph_d;
      core_q     <= core_d;
      done_q     <= done_d;
      ack_q      <= ack_d;
      cause_q    <= cause_d;
    end
  end

  assign rst_periph_n = periph_q;
  assign rst_core_n   = core_q;
  assign seq_done     = done_q;
  assign sreq_ack     = ack_q;
  assign reset_cause  = cause_q;

endmodule
